alog_pipe: RTL and testbench

//  Parametrised, pipelined log-domain to linear (antilog, base-2) converter with valid/ready handshake.

---
 rtl/alog_pipe.sv | 142 ++++++++++++++
 tb/tb_alog_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alog_pipe.sv
// alog_pipe: two-stage base-2 antilog converter (log value {E,F} -> {1,F} * 2^E) with valid/ready.
// Optional build macro ALOG_ROUND_EN selects round-half-up on the shifted-out bits instead of truncation.
module alog_pipe #(
   parameter int IN_W   = 18,
   parameter int FRAC_W = 12,
   parameter int OUT_W  = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_ovf,
   output logic              out_udf
);

   localparam int INT_W = IN_W - FRAC_W;
   localparam int PAD_W = OUT_W - FRAC_W - 1;
   localparam int SH_W  = $clog2(OUT_W + 2);
   localparam logic [INT_W:0]  OUT_W_K = (INT_W+1)'(OUT_W);
   localparam logic [SH_W-1:0] SH_MAX  = SH_W'(OUT_W + 1);

   logic              s1_v;
   logic              s2_v;
   logic              s1_ld_s;
   logic              s2_ld_s;

   logic [INT_W-1:0]  e_s;
   logic [FRAC_W-1:0] f_s;
   logic [INT_W:0]    k_s;
   logic              ovf_s;
   logic              zero_sh_s;
   logic [SH_W-1:0]   sh_s;

   logic [FRAC_W:0]   s1_m_r;
   logic [SH_W-1:0]   s1_sh_r;
   logic              s1_ovf_r;
   logic              s1_zero_sh_r;

   logic [OUT_W-1:0]  v_s;
   logic [OUT_W-1:0]  res_s;
   logic              udf_s;

   assign s2_ld_s   = !s2_v || out_ready;
   assign s1_ld_s   = !s1_v || s2_ld_s;
   assign in_ready  = s1_ld_s;
   assign out_valid = s2_v;

   // Decode E, F into the shift amount; k is E negated in one extra bit so E = min is not wrapped.
   assign e_s       = in_data[IN_W-1:FRAC_W];
   assign f_s       = in_data[FRAC_W-1:0];
   assign k_s       = -{e_s[INT_W-1], e_s};
   assign ovf_s     = !e_s[INT_W-1] && (e_s != {INT_W{1'b0}});
   assign zero_sh_s = !ovf_s && (k_s >= OUT_W_K);

   // Clamp the shift so anything past OUT_W becomes a single "fully shifted out" code.
   always_comb begin
      sh_s = {SH_W{1'b0}};
      if (ovf_s) begin
         sh_s = {SH_W{1'b0}};
      end else if (k_s > OUT_W_K) begin
         sh_s = SH_MAX;
      end else begin
         sh_s = k_s[SH_W-1:0];
      end
   end

   // Stage 1 register: mantissa with hidden one, shift amount and range flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v         <= 1'b0;
         s1_m_r       <= {(FRAC_W+1){1'b0}};
         s1_sh_r      <= {SH_W{1'b0}};
         s1_ovf_r     <= 1'b0;
         s1_zero_sh_r <= 1'b0;
      end else if (s1_ld_s) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_m_r       <= {1'b1, f_s};
            s1_sh_r      <= sh_s;
            s1_ovf_r     <= ovf_s;
            s1_zero_sh_r <= zero_sh_s;
         end
      end
   end

   assign v_s = OUT_W'(s1_m_r) << PAD_W;

`ifdef ALOG_ROUND_EN
   logic [OUT_W:0] wide_s;

   // The guard bit below the LSB is the first bit shifted out; adding it gives round-half-up.
   assign wide_s = {v_s, 1'b0} >> s1_sh_r;

   // Shifted result with rounding; at k == OUT_W only the guard bit survives.
   always_comb begin
      res_s = {OUT_W{1'b1}};
      if (s1_ovf_r) begin
         res_s = {OUT_W{1'b1}};
      end else if (s1_zero_sh_r) begin
         res_s = OUT_W'(wide_s[0]);
      end else begin
         res_s = wide_s[OUT_W:1] + OUT_W'(wide_s[0]);
      end
   end
`else
   // Shifted result with truncation.
   always_comb begin
      res_s = {OUT_W{1'b1}};
      if (s1_ovf_r) begin
         res_s = {OUT_W{1'b1}};
      end else if (s1_zero_sh_r) begin
         res_s = {OUT_W{1'b0}};
      end else begin
         res_s = v_s >> s1_sh_r;
      end
   end
`endif

   assign udf_s = !s1_ovf_r && (res_s == {OUT_W{1'b0}});

   // Stage 2 register: output data and flags hold while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v     <= 1'b0;
         out_data <= {OUT_W{1'b0}};
         out_ovf  <= 1'b0;
         out_udf  <= 1'b0;
      end else if (s2_ld_s) begin
         s2_v <= s1_v;
         if (s1_v) begin
            out_data <= res_s;
            out_ovf  <= s1_ovf_r;
            out_udf  <= udf_s;
         end
      end
   end

endmodule

// File: tb/tb_alog_pipe.sv
// Self-checking bench for alog_pipe: directed vectors, backpressure, random traffic and reset,
// with an in-order scoreboard fed by an independent arithmetic reference model.
module tb_alog_pipe;

   localparam int IN_W   = 18;
   localparam int FRAC_W = 12;
   localparam int OUT_W  = 19;

   typedef logic [OUT_W+1:0] res_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   in_data;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic              out_ovf;
   logic              out_udf;

   always #5 clk = ~clk;

   alog_pipe #(.IN_W(IN_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ovf(out_ovf), .out_udf(out_udf)
   );

   res_t sb[$];
   int   pass_cnt  = 0;
   int   fail_cnt  = 0;
   int   total_cnt = 0;
   logic held_v    = 1'b0;
   res_t held;
   int   acc;
   int   emit;
   logic stall_seen;

   // Reference: {1,F} * 2^E computed on integers, packed as {data, ovf, udf}.
   function automatic res_t model(input logic [IN_W-1:0] d);
      int     e;
      int     k;
      longint v;
      longint r;
      e = int'($signed(d[IN_W-1:FRAC_W]));
      if (e > 0) return {{OUT_W{1'b1}}, 1'b1, 1'b0};
      k = -e;
      v = longint'((1 << FRAC_W) + int'(d[FRAC_W-1:0])) << (OUT_W - FRAC_W - 1);
`ifdef ALOG_ROUND_EN
      if (k == 0)          r = v;
      else if (k > OUT_W)  r = 0;
      else                 r = (v + (longint'(1) << (k - 1))) >> k;
`else
      if (k >= OUT_W)      r = 0;
      else                 r = v >> k;
`endif
      return {r[OUT_W-1:0], 1'b0, (r == 0)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes on the falling edge, then step past the rising edge.
   task automatic tick();
      res_t e;
      acc  = 0;
      emit = 0;
      @(negedge clk);
      if (rst) begin
         sb.delete();
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            check("stall_valid", out_valid, 1);
            check("stall_hold", {out_data, out_ovf, out_udf}, held);
         end
         if (in_valid && !in_ready) stall_seen = 1'b1;
         if (in_valid && in_ready) begin
            sb.push_back(model(in_data));
            acc = 1;
         end
         if (out_valid && out_ready) begin
            emit = 1;
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("out", {out_data, out_ovf, out_udf}, e);
            end
         end
         held_v = out_valid && !out_ready;
         held   = {out_data, out_ovf, out_udf};
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) tick();
      check("drain_empty", sb.size(), 0);
   endtask

   // Single directed vector with latency check and a spec constant.
   task automatic directed(input string tag, input logic [IN_W-1:0] din, input res_t exp);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = din;
      tick();
      check({tag, "_acc"}, acc, 1);
      in_valid = 1'b0;
      check({tag, "_lat1"}, out_valid, 0);
      tick();
      check({tag, "_lat2"}, out_valid, 1);
      check(tag, {out_data, out_ovf, out_udf}, exp);
      tick();
   endtask

   logic [IN_W-1:0] bp_vec [8];
   int sent;
   int got;

   initial begin
      bp_vec = '{18'h00000, 18'h3FFFF, 18'h2E000, 18'h01000,
                 18'h2D000, 18'h3A123, 18'h20000, 18'h3F800};
      rst = 1'b1; in_valid = 1'b0; in_data = {IN_W{1'b0}}; out_ready = 1'b0;
      stall_seen = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data, 0);
      check("rst_ovf",       out_ovf, 0);
      check("rst_udf",       out_udf, 0);
      check("rst_in_ready",  in_ready, 1);

      directed("e0",    18'h00000, {19'h40000, 1'b0, 1'b0});
      directed("em1",   18'h3FFFF, {19'h3FFE0, 1'b0, 1'b0});
      directed("em18",  18'h2E000, {19'h00001, 1'b0, 1'b0});
      directed("ep1",   18'h01000, {19'h7FFFF, 1'b1, 1'b0});
`ifdef ALOG_ROUND_EN
      directed("em19",  18'h2D000, {19'h00001, 1'b0, 1'b0});
`else
      directed("em19",  18'h2D000, {19'h00000, 1'b0, 1'b1});
`endif
      directed("emin",  18'h20000, {19'h00000, 1'b0, 1'b1});
      directed("emax",  18'h1F000, {19'h7FFFF, 1'b1, 1'b0});

      // Backpressure: 8 back-to-back inputs, consumer stalled in cycles 3-7.
      sent = 0; got = 0; stall_seen = 1'b0;
      for (int cyc = 0; cyc < 60 && (sent < 8 || sb.size() != 0); cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 7);
         in_valid  = (sent < 8);
         in_data   = bp_vec[sent & 7];
         tick();
         sent += acc;
         got  += emit;
      end
      check("bp_inready_drop", stall_seen, 1);
      check("bp_sent", sent, 8);
      check("bp_got", got, 8);
      drain();

      // Random traffic with 50% consumer readiness.
      sent = 0;
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 8000 && sent < 1000; cyc++) begin
         if (!in_valid || acc != 0) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = IN_W'($urandom);
         end
         out_ready = $urandom_range(0, 1) != 0;
         tick();
         sent += acc;
      end
      check("rand_sent", sent, 1000);
      drain();

      // Full throughput with the consumer always ready.
      sent = 0; got = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = IN_W'($urandom);
         tick();
         sent += acc;
         got  += emit;
      end
      check("tput_acc", sent, 20);
      check("tput_emit", got, 18);
      drain();

      // Reset with two items in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 18'h3FFFF;
      tick();
      sent = acc;
      in_data = 18'h00000;
      tick();
      sent += acc;
      check("rst_fill", sent, 2);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_out_valid", out_valid, 0);
      check("rst2_out_data",  out_data, 0);
      check("rst2_ovf",       out_ovf, 0);
      check("rst2_udf",       out_udf, 0);
      check("rst2_in_ready",  in_ready, 1);
      out_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         got += emit;
      end
      check("rst2_no_stale", got, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
